// File: rtl/imu_pkg.sv
// Shared IMU sample format plus tilt encoding and 16-bit saturation helper.
// Imported by the IMU reader and by every consumer of its samples.
package imu_pkg;

    typedef struct packed {
        logic signed [15:0] x, y, z;
        logic signed [15:0] gx, gy, gz;
    } data_t;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        POS  = 2'b01,
        NEG  = 2'b11
    } tilt_t;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return 16'sh7fff;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/axis_filter.sv
// One accelerometer axis: offset removal with saturation, EMA smoothing, deadzone tilt.
// Latency: 1 edge stage-1 (corr) + 1 edge stage-2 (filt/tilt).
// No backpressure: loads whenever the enables are high.
module axis_filter
    import imu_pkg::*;
#(
    parameter int unsigned        ALPHA_SHIFT = 2,
    parameter logic signed [15:0] DEADZONE    = 16'sd1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sample,
    input  logic signed [15:0] off,
    input  logic               s1_load,
    input  logic               s2_load,
    input  logic               arm_first,
    output logic signed [15:0] filt,
    output logic [1:0]         tilt
);

    logic signed [15:0] corr;
    logic signed [15:0] filt_next;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic               first;

    // The EMA result lies between filt and corr, so dropping bit 16 is lossless.
    assign diff      = 17'(corr) - 17'(filt);
    assign step      = diff >>> ALPHA_SHIFT;
    assign filt_next = first ? corr : 16'(17'(filt) + step);

    always_ff @(posedge clk) begin
        if (reset) begin
            corr  <= '0;
            filt  <= '0;
            tilt  <= ZERO;
            first <= 1'b0;
        end else begin
            if (s1_load)
                corr <= sat16(17'(sample) - 17'(off));
            if (s2_load) begin
                filt  <= filt_next;
                first <= 1'b0;
                if (filt_next > DEADZONE)
                    tilt <= POS;
                else if (filt_next < -DEADZONE)
                    tilt <= NEG;
                else
                    tilt <= ZERO;
            end
            if (arm_first)
                first <= 1'b1;
        end
    end

endmodule

// File: rtl/imu_tilt.sv
// Tilt detector: sample-change detect, zero-offset calibration, per-axis filtering.
// Latency: 2 edges from a changed imu_data to out_valid/filt/tilt.
// No backpressure: every changed sample in RUN yields one out_valid pulse.
module imu_tilt
    import imu_pkg::*;
#(
    parameter int unsigned        CAL_LOG2    = 4,
    parameter int unsigned        ALPHA_SHIFT = 2,
    parameter logic signed [15:0] DEADZONE    = 16'sd1000
) (
    input  logic               clk,
    input  logic               reset,
    input  data_t              imu_data,
    input  logic               recal,
    output logic signed [15:0] filt_x,
    output logic signed [15:0] filt_y,
    output logic [1:0]         tilt_x,
    output logic [1:0]         tilt_y,
    output logic               out_valid,
    output logic               calibrated
);

    localparam int ACC_W = 16 + CAL_LOG2;
    localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

    data_t                    prev_data;
    state_t                   state;
    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic signed [ACC_W-1:0]  sum_x, sum_y;
    logic [CAL_LOG2-1:0]      cnt;
    logic signed [15:0]       off_x, off_y;
    logic                     s1_valid;
    logic                     new_sample;
    logic                     s1_load, s2_load, arm_first;

    assign new_sample = (imu_data != prev_data);
    assign sum_x      = acc_x + ACC_W'(imu_data.x);
    assign sum_y      = acc_y + ACC_W'(imu_data.y);

    // recal outranks everything: it drops a coincident sample and any in-flight update.
    assign s1_load   = (state == RUN) && new_sample && !recal;
    assign s2_load   = s1_valid && !recal;
    assign arm_first = (state == CAL) && new_sample && !recal && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_data  <= '0;
            state      <= CAL;
            acc_x      <= '0;
            acc_y      <= '0;
            cnt        <= '0;
            off_x      <= '0;
            off_y      <= '0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            calibrated <= 1'b0;
        end else begin
            prev_data <= imu_data;
            s1_valid  <= s1_load;
            out_valid <= s2_load;
            if (recal) begin
                state      <= CAL;
                acc_x      <= '0;
                acc_y      <= '0;
                cnt        <= '0;
                calibrated <= 1'b0;
            end else if (state == CAL && new_sample) begin
                if (cnt == CNT_LAST) begin
                    off_x      <= 16'(sum_x >>> CAL_LOG2);
                    off_y      <= 16'(sum_y >>> CAL_LOG2);
                    acc_x      <= '0;
                    acc_y      <= '0;
                    cnt        <= '0;
                    state      <= RUN;
                    calibrated <= 1'b1;
                end else begin
                    acc_x <= sum_x;
                    acc_y <= sum_y;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    axis_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .DEADZONE(DEADZONE)) u_filt_x (
        .clk       (clk),
        .reset     (reset),
        .sample    (imu_data.x),
        .off       (off_x),
        .s1_load   (s1_load),
        .s2_load   (s2_load),
        .arm_first (arm_first),
        .filt      (filt_x),
        .tilt      (tilt_x)
    );

    axis_filter #(.ALPHA_SHIFT(ALPHA_SHIFT), .DEADZONE(DEADZONE)) u_filt_y (
        .clk       (clk),
        .reset     (reset),
        .sample    (imu_data.y),
        .off       (off_y),
        .s1_load   (s1_load),
        .s2_load   (s2_load),
        .arm_first (arm_first),
        .filt      (filt_y),
        .tilt      (tilt_y)
    );

endmodule

// File: doc/imu_tilt.md
# imu_tilt

Downstream consumer of the IMU reader's `data_t` output. Detects each new IMU sample and runs a zero-offset calibration over the first 2^CAL_LOG2 samples. After that it removes the offset from accelerometer X/Y, smooths each axis with a saturating exponential moving average, and reports a per-axis tilt direction with a deadzone. It sits between the IMU reader and the display/game logic, which use `tilt_x`/`tilt_y` and `out_valid`.

## Interface
- CAL_LOG2, 4: log2 of the number of calibration samples (16).
- ALPHA_SHIFT, 2: EMA weight is 2^-ALPHA_SHIFT.
- DEADZONE, 16'sd1000: magnitude threshold for a non-zero tilt.
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- imu_data  input  data_t (96)  latest IMU sample. Only `x` and `y` are used.
- recal  input  1  one-cycle request to restart calibration.
- filt_x, filt_y  output  16 signed  filtered, offset-corrected acceleration.
- tilt_x, tilt_y  output  2  direction: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
- out_valid  output  1  one-cycle pulse when filt/tilt update.
- calibrated  output  1  high while in RUN.

## Operation
- **New-sample detect.** `prev_data` register (reset 0) captures `imu_data` every cycle.
  - `new_sample` = (`imu_data` != `prev_data`).
  - An identical repeated sample is not seen. This is acceptable: the IMU produces a new sample at most once per ~1M cycles.
- **State machine** with states CAL (after reset) and RUN.
- **CAL:**
  - On each accepted sample: `acc_x += x`, `acc_y += y`, `cnt++`.
  - `acc` is signed, 16+CAL_LOG2 bits. `cnt` is CAL_LOG2 bits.
  - On the sample where `cnt == 2^CAL_LOG2-1`:
    - `off_x <= (acc_x + x) >>> CAL_LOG2` (arithmetic shift), same for Y.
    - State → RUN, `calibrated <= 1`, `first <= 1`.
  - No `out_valid` is produced in CAL.
- **RUN, stage 1:**
  - `corr = sat16(x - off_x)`, computed at 17 bits and clamped to [-32768, 32767]. Same for Y.
  - Registered together with `s1_valid`.
- **RUN, stage 2:**
  - If `first`: `filt <= corr`, `first <= 0`.
  - Otherwise: `filt <= filt + ((corr - filt) >>>ALPHA_SHIFT)`, computed at 17 bits. The result always fits in 16 bits.
  - Tilt is computed from the new `filt`:
    - `filt > DEADZONE` → +1.
    - `filt < -DEADZONE` → -1.
    - Otherwise → 0 (equality counts as 0).
  - `out_valid <= 1` for one cycle.
- **recal:**
  - State → CAL; `acc`, `cnt`, `calibrated` and `s1_valid` are cleared.
  - `filt`, `tilt` and offsets hold their last values until the next RUN update.
  - recal in the same cycle as `new_sample`: recal wins and the sample is discarded (it is not accumulated).
  - recal while a sample is in stage 1: the stage-2 update is suppressed and no `out_valid` is produced.
- **Reset:**
  - All outputs 0, `calibrated` 0, offsets 0, accumulators 0, state CAL.
  - Reset mid-operation aborts everything within one cycle.

## Timing
- `imu_data` changes after edge E0. `new_sample` is high during the cycle E0→E1.
  - Edge E1: CAL accumulate/offset update, or RUN stage-1 register.
  - Edge E2: `filt`/`tilt` update and `out_valid` rises; it falls at E3.
  - Latency is 2 edges.
- `calibrated` rises at E1 of the final calibration sample.
- Fully pipelined with no back-pressure: back-to-back changes on consecutive cycles each produce an `out_valid` 2 edges later.

## Structure
- Move `data_t` into shared package `imu_pkg`, so the IMU reader and this block import one definition.
- Add to `imu_pkg`:
  - `tilt_t` enum: NEG = 2'b11, ZERO = 2'b00, POS = 2'b01.
  - `sat16` function.
- Sub-module `axis_filter`, instantiated twice (X and Y). It owns the offset subtract, saturation, EMA, deadzone compare and the `first` handling.
- The top level owns change detection, the CAL/RUN FSM, the accumulators and `out_valid`.

## Test plan
- **Reset:** assert reset with garbage on `imu_data`. Expect all outputs 0 and `calibrated` 0; a later change gives no `out_valid` until calibration completes.
- **Calibration:** 16 samples with x=100, y=-200, `z` toggled to force change.
  - `calibrated` rises at E1 of the 16th sample.
  - Offsets are 100 / -200.
  - No `out_valid` pulses.
- **Filtering:** after calibration, x=4100 gives `filt_x`=4000, `tilt_x`=01, `out_valid` at E2. Then x=100 gives `filt_x`=3000. Y at offset gives `filt_y`=0, `tilt_y`=00.
- **Saturation:** calibrate with x=-30000, then x=30000. Expect `filt_x`=32767 with no wrap; repeated samples stay at 32767.
- **Deadzone boundary:**
  - `corr` = 1000 (first RUN sample) → `tilt_x`=00.
  - Recalibrate, then `corr` = 1001 → 01.
  - Recalibrate, then `corr` = -1001 → 11.
- **recal collision:** `recal` in the same cycle as a new sample. Expect the sample dropped, `calibrated`=0, `cnt`=0, no `out_valid`, `filt` held. Then 16 more samples are required to return to RUN.
